// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Counter widths are derived from the scanner parameters through cnt_w().
package seg_display_scanner_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_NUM_DIGITS  = 4;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SLOT_W  = cnt_w(DEF_REFRESH_DIV);
  localparam int DEF_DIGIT_W = cnt_w(DEF_NUM_DIGITS);

endpackage

// File: rtl/seg_display_scanner_if.sv
// Value-producer side of the scanner: load strobe with payload, plus the
// commit acknowledge and frame pulse returned to the producer.
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  // Handshake: load is a one-cycle strobe qualifying load_value/load_dp in
  // that cycle; there is no back-pressure. load_ack pulses once, the cycle
  // after the frame boundary at which the most recent load became visible.
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic [NUM_DIGITS-1:0]     load_dp;
  logic                      load_ack;
  logic                      frame_done;

  modport master (
    output load, load_value, load_dp,
    input  load_ack, frame_done
  );

  modport slave (
    input  load, load_value, load_dp,
    output load_ack, frame_done
  );
endinterface

// File: rtl/seg_display_scanner_segments_converter.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module segments_converter (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h18;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Round-robin common-anode digit scanner with frame-aligned double buffering.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] digit_enable,
  seg_display_scanner_if.slave  bus,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int SLOT_W  = cnt_w(REFRESH_DIV);
  localparam int DIGIT_W = cnt_w(NUM_DIGITS);
  localparam int VAL_W   = 4 * NUM_DIGITS;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [DIGIT_W-1:0]    digit_idx;
  logic [VAL_W-1:0]      stage_value;
  logic [NUM_DIGITS-1:0] stage_dp;
  logic [VAL_W-1:0]      disp_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic                  pending;
  logic                  ack_q;
  logic                  done_q;

  logic                  slot_last;
  logic                  fb;
  logic                  in_guard;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] lzb;
  logic [NUM_DIGITS-1:0] an_drive;
  logic [6:0]            dec_seg;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign fb        = slot_last && (digit_idx == DIGIT_LAST);
  assign in_guard  = (int'(slot_cnt) < GUARD_CYCLES);
  assign an_drive  = ~(NUM_DIGITS'(1) << digit_idx);

  assign bus.load_ack   = ack_q;
  assign bus.frame_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_last) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // A load on the boundary cycle itself bypasses staging and wins over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_value <= '0;
      stage_dp    <= '0;
      disp_value  <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= fb;
      if (fb) begin
        if (bus.load) begin
          disp_value <= bus.load_value;
          disp_dp    <= bus.load_dp;
        end else if (pending) begin
          disp_value <= stage_value;
          disp_dp    <= stage_dp;
        end
        pending <= 1'b0;
        ack_q   <= bus.load | pending;
      end else if (bus.load) begin
        stage_value <= bus.load_value;
        stage_dp    <= bus.load_dp;
        pending     <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk down from the top digit; a digit is dark while everything above it is zero.
  always_comb begin
    lzb        = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (disp_value[4*i +: 4] == 4'h0);
      lzb[i]     = upper_zero;
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIGIT_W'(i)) begin
        cur_nibble = disp_value[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_en     = digit_enable[i];
        cur_blank  = lzb[i];
      end
    end
  end

  segments_converter u_segments_converter (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else if (in_guard || !cur_en || cur_blank) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_drive;
      seg_n <= dec_seg;
      dp_n  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner (4 digits, 8-cycle slots, 2 guard cycles).
// Expected pins are queued per cycle index; a negedge monitor pops and compares.
module tb_seg_display_scanner;

  localparam int ND = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] digit_enable = 4'hF;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] an_n;

  seg_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seg_display_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_enable (digit_enable),
    .bus          (bus),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .an_n         (an_n)
  );

  // clock / reset / cycle index (0 while in reset, n after n released edges)
  always #5 clk = ~clk;

  int cyc = -1;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // scoreboard: {an_n, seg_n, dp_n, load_ack, frame_done} keyed by cycle index
  logic [13:0] exp_q[$];
  int          cyc_q[$];
  int          total   = 0;
  int          bad     = 0;
  int          ack_cnt = 0;
  string       tname   = "init";

  always @(negedge clk) begin
    logic [13:0] got;
    logic [13:0] want;
    if (bus.load_ack === 1'b1) ack_cnt++;
    got = {an_n, seg_n, dp_n, bus.load_ack, bus.frame_done};
    while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL %s missed check at cyc=%0d (now cyc=%0d)", tname, cyc_q[0], cyc);
      void'(cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
      void'(cyc_q.pop_front());
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cyc=%0d got an=%h seg=%h dp=%b ack=%b fd=%b need an=%h seg=%h dp=%b ack=%b fd=%b",
                 tname, cyc, got[13:10], got[9:3], got[2], got[1], got[0],
                 want[13:10], want[9:3], want[2], want[1], want[0]);
      end
    end
  end

  // driver / expectation tasks
  task automatic push(input int c, input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input logic ack, input logic fd);
    cyc_q.push_back(c);
    exp_q.push_back({an, seg, dp, ack, fd});
  endtask

  task automatic push_g(input int c, input logic ack, input logic fd);
    push(c, 4'hF, 7'h7F, 1'b1, ack, fd);
  endtask

  task automatic push_reset();
    push(0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_d(input int c, input int d, input logic [6:0] seg, input logic dp);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    push(c, an, seg, dp, 1'b0, 1'b0);
  endtask

  // digit d driven while the display register holds all zeros
  task automatic push_z(input int c, input int d, input logic ack, input logic fd);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    if (LZB && d > 0) push(c, 4'hF, 7'h7F, 1'b1, ack, fd);
    else              push(c, an, 7'h40, 1'b1, ack, fd);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc != c) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("FAIL %s wait_cyc timeout got cyc=%0d need cyc=%0d", tname, cyc, c);
        return;
      end
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (cyc_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("FAIL %s queue drain timeout got pending=%0d need 0", tname, cyc_q.size());
        cyc_q.delete();
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.load       = 1'b1;
    bus.load_value = v;
    bus.load_dp    = dp;
    @(posedge clk); #1;
    bus.load       = 1'b0;
  endtask

  task automatic reset_begin();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic reset_end();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_acks(input int a0, input int n);
    total++;
    if (ack_cnt - a0 != n) begin
      bad++;
      $display("FAIL %s ack_count got=%0d need=%0d", tname, ack_cnt - a0, n);
    end
  endtask

  // stimulus
  initial begin
    int a0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.load_dp    = '0;
    @(posedge clk); #1;

    tname = "scan";
    reset_begin();
    push_reset();
    reset_end();
    push_g(1, 0, 0);
    push_g(2, 0, 0);
    push_z(3, 0, 0, 0);
    push_z(8, 0, 0, 0);
    push_g(9, 0, 0);
    push_z(11, 1, 0, 0);
    push_z(31, 3, 0, 0);
    push_z(32, 3, 0, 1);
    push_g(33, 0, 0);
    push_z(64, 3, 0, 1);
    wait_empty();

    tname = "load_1234";
    reset_begin();
    push_reset();
    reset_end();
    a0 = ack_cnt;
    push_z(28, 3, 0, 0);
    push_z(32, 3, 1, 1);
    push_g(33, 0, 0);
    push_d(35, 0, 7'h19, 1'b1);
    push_d(43, 1, 7'h30, 1'b1);
    push_d(51, 2, 7'h24, 1'b1);
    push_d(59, 3, 7'h79, 1'b1);
    push_d(84, 2, 7'h24, 1'b1);
    wait_cyc(5);
    pulse_load(16'h1234, 4'h0);
    wait_cyc(84);
    check_acks(a0, 1);

    tname = "mid_reset";
    reset_begin();
    push_reset();
    reset_end();
    push_z(3, 0, 0, 0);
    push_z(11, 1, 0, 0);
    wait_empty();

    tname = "last_wins";
    reset_begin();
    push_reset();
    reset_end();
    a0 = ack_cnt;
    push_z(32, 3, 1, 1);
    push_g(33, 0, 0);
    push_d(35, 0, 7'h12, 1'b1);
    push_d(43, 1, 7'h12, 1'b1);
    push_d(51, 2, 7'h12, 1'b1);
    push_d(59, 3, 7'h12, 1'b1);
    push(64, 4'h7, 7'h12, 1'b1, 1'b0, 1'b1);
    wait_cyc(3);
    pulse_load(16'hAAAA, 4'h0);
    wait_cyc(10);
    pulse_load(16'h5555, 4'h0);
    wait_empty();
    check_acks(a0, 1);

    tname = "digit_enable";
    reset_begin();
    digit_enable = 4'b0101;
    push_reset();
    reset_end();
    push_g(11, 0, 0);
    push_d(35, 0, 7'h00, 1'b1);
    push_g(43, 0, 0);
    push_d(51, 2, 7'h00, 1'b1);
    push_g(59, 0, 0);
    wait_cyc(5);
    pulse_load(16'h8888, 4'h0);
    wait_empty();
    digit_enable = 4'hF;

    tname = "fb_load";
    reset_begin();
    push_reset();
    reset_end();
    a0 = ack_cnt;
    push_z(32, 3, 1, 1);
    push_g(33, 0, 0);
    push_d(35, 0, 7'h00, 1'b0);
    push_d(43, 1, 7'h78, 1'b1);
    push_d(51, 2, 7'h02, 1'b1);
    push_d(59, 3, 7'h12, 1'b1);
    wait_cyc(5);
    pulse_load(16'hAAAA, 4'h0);
    wait_cyc(31);
    pulse_load(16'h5678, 4'b0001);
    wait_empty();
    check_acks(a0, 1);

    tname = "lead_zero";
    reset_begin();
    push_reset();
    reset_end();
    push_d(35, 0, 7'h40, 1'b1);
    push_d(43, 1, 7'h19, 1'b1);
    if (LZB) begin
      push_g(51, 0, 0);
      push_g(59, 0, 0);
    end else begin
      push_d(51, 2, 7'h40, 1'b1);
      push_d(59, 3, 7'h40, 1'b1);
    end
    wait_cyc(5);
    pulse_load(16'h0040, 4'h0);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
